// File: rtl/a1csah_seq128.sv
// a1csah_seq128 -- 128-bit sequential adder built from one reused 32-bit
// slice adder (a1csah32bits). One slice is processed per cycle, least
// significant first, while group generate/propagate are folded up across
// the slices.
//
// Optional feature: define A1CSAH_SEQ_B2B_EN to accept a new operation in
// the same cycle a finished result is consumed (5-cycle throughput). The
// default build inserts one idle cycle between operations (6 cycles).

// 32-bit slice adder with group generate/propagate outputs.
module a1csah32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout,
    output logic        g,
    output logic        p
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

    // The slice propagates only when every bit pair differs. In that case
    // a + b is all ones and the carry-out is exactly cin; otherwise the
    // carry-out does not depend on cin and equals the group generate.
    assign p = &(a ^ b);
    assign g = cout & ~p;

endmodule

module a1csah_seq128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] s,
    output logic         cout,
    output logic         gen,
    output logic         prop
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [1:0]   idx;
    logic [127:0] a_reg;
    logic [127:0] b_reg;
    logic         carry_reg;
    logic         gen_acc;
    logic         prop_acc;
    logic         accept;

    logic [31:0]  slice_a;
    logic [31:0]  slice_b;
    logic [31:0]  slice_s;
    logic         slice_cout;
    logic         slice_g;
    logic         slice_p;

    // Operand acceptance: idle only, or also on the result hand-off cycle.
`ifdef A1CSAH_SEQ_B2B_EN
    assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    assign accept = in_valid & in_ready;

    // Route the current 32-bit slice of the latched operands to the adder.
    assign slice_a = a_reg[{idx, 5'b0} +: 32];
    assign slice_b = b_reg[{idx, 5'b0} +: 32];

    a1csah32bits u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout),
        .g    (slice_g),
        .p    (slice_p)
    );

    // Result flags come straight from the accumulators; they are final in DONE.
    assign cout = carry_reg;
    assign gen  = gen_acc;
    assign prop = prop_acc;

    // Sequencer: latch operands, walk the four slices, hold the result.
    // NOTE: all state here uses <= so every register samples pre-edge values;
    // blocking assignments would let later statements see updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            s         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            gen_acc   <= 1'b0;
            prop_acc  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            gen_acc   <= 1'b0;
            prop_acc  <= 1'b1;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            state     <= BUSY;
        end else begin
            case (state)
                BUSY: begin
                    s[{idx, 5'b0} +: 32] <= slice_s;
                    carry_reg            <= slice_cout;
                    gen_acc              <= slice_g | (slice_p & gen_acc);
                    prop_acc             <= prop_acc & slice_p;
                    idx                  <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a1csah_seq128.sv
// tb_a1csah_seq128 -- directed self-checking bench for a1csah_seq128.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_a1csah_seq128;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] s;
    logic         cout;
    logic         gen;
    logic         prop;

    int checks = 0;
    int errors = 0;

    a1csah_seq128 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .gen       (gen),
        .prop      (prop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation: accept, latency, result, optional hold, release.
    task automatic do_op(input string tag, input logic [127:0] va, input logic [127:0] vb,
                         input logic vc, input logic [127:0] es, input logic ec,
                         input logic eg, input logic ep, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // Scramble inputs after the accept edge; they must be ignored.
        in_valid = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_s"}, s, es);
        check({tag, "_flags"}, {cout, gen, prop}, {ec, eg, ep});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = {4{$urandom}};
            b = {4{$urandom}};
            @(negedge clk);
            check({tag, "_hold_s"}, s, es);
            check({tag, "_hold_flags"}, {out_valid, cout, gen, prop}, {1'b1, ec, eg, ep});
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_release_valid"}, out_valid, 0);
        check({tag, "_release_ready"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int acc_cnt;
        int acc_t [2];
        int res_cnt;
        logic [127:0] res [2];
        int exp_gap;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_ready", in_ready, 0);
        check("reset_s", s, 0);
        check("reset_flags", {cout, gen, prop}, 3'b000);
        rst = 1'b0;
        #1;
        check("post_reset_ready", in_ready, 1);

        // Carry ripples through all four slices.
        do_op("all_ones_cin", {128{1'b1}}, 128'd0, 1'b1, 128'd0, 1'b1, 1'b0, 1'b1, 0);
        // Carry crosses slice 0 -> 1 only.
        do_op("cross01", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
              128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 0);
        // Top-bit overflow, held three cycles in DONE.
        do_op("msb_hold", {1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 3);
        // Every slice generates.
        do_op("gen_all", {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 1'b0,
              {32'h1, 32'h1, 32'h1, 32'h0}, 1'b1, 1'b1, 1'b0, 0);
        // Pure propagate, no carry-in.
        do_op("prop_all", {32{4'hA}}, {32{4'h5}}, 1'b0, {128{1'b1}}, 1'b0, 1'b0, 1'b1, 0);

        // Reset mid-operation at BUSY idx=2.
        a = 128'd3; b = 128'd4; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);              // accept edge done, idx=0
        in_valid = 1'b0;
        @(negedge clk);              // idx=1
        @(negedge clk);              // idx=2
        rst = 1'b1;
        #1;
        check("rst_busy_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_abort_valid", out_valid, 0);
        check("rst_abort_s", s, 0);
        check("rst_abort_ready", in_ready, 1);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        check("rst_no_pulse", cyc, 0);
        do_op("after_rst", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
              128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b1,
              128'h2345_6789_ABCD_F001_20FE_DCBA_9876_5433, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back requests with in_valid and out_ready held high.
`ifdef A1CSAH_SEQ_B2B_EN
        exp_gap = 5;
`else
        exp_gap = 6;
`endif
        acc_cnt = 0; res_cnt = 0;
        acc_t[0] = 0; acc_t[1] = 0; res[0] = '0; res[1] = '0;
        a = 128'd5; b = 128'd7; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (acc_cnt == 1 && t == acc_t[0] + 1) begin
                a = 128'd100; b = 128'd200; cin = 1'b1;
            end
            if (out_valid && res_cnt < 2) begin
                res[res_cnt] = s;
                res_cnt++;
            end
            if (in_valid && in_ready && acc_cnt < 2) begin
                acc_t[acc_cnt] = t;
                acc_cnt++;
                if (acc_cnt == 2) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    continue;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("b2b_accepts", acc_cnt, 2);
        check("b2b_gap", acc_t[1] - acc_t[0], exp_gap);
        check("b2b_results", res_cnt, 2);
        check("b2b_res0", res[0], 128'd12);
        check("b2b_res1", res[1], 128'd301);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
